// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared constants, types and helpers for the binarized-network datapath.
//   WIDTH     : width of a PE psum (two's complement)
//   ACC_WIDTH : width of the signed accumulator and of the BN threshold
//   KBITS     : bits per packed activation word (3x3 kernel)
// sat_add() adds a sign-extended psum to an accumulator value and clamps the
// result to the accumulator range.
// -----------------------------------------------------------------------------
package bnn_pkg;

  localparam int WIDTH     = 14;
  localparam int ACC_WIDTH = 18;
  localparam int KBITS     = 9;
  // Wide enough to count up to KBITS so the "word complete" value is representable.
  localparam int IDX_WIDTH = $clog2(KBITS + 1);

  typedef logic signed [WIDTH-1:0]     psum_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef logic        [KBITS-1:0]     act_word_t;
  typedef logic        [IDX_WIDTH-1:0] bit_idx_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // One guard bit is enough: the psum is narrower than the accumulator, so
  // overflow shows up as a disagreement between the two top bits.
  function automatic acc_t sat_add(input acc_t a, input psum_t b);
    logic signed [ACC_WIDTH:0] sum;
    sum = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
      return sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    return sum[ACC_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/psum_binarizer_if.sv
// -----------------------------------------------------------------------------
// psum_binarizer_if
// Bundles the psum input stream, flush pulse and packed-activation output of
// psum_binarizer.
//   master : producer/consumer side (drives *_in, observes *_out)
//   slave  : the binarizer itself
// When PSUM_BINARIZER_POLARITY_EN is defined the bundle also carries
// polarity_in, sampled together with the last_in beat.
// -----------------------------------------------------------------------------
interface psum_binarizer_if;
  import bnn_pkg::*;

  logic      psum_valid_in;
  logic      psum_ready_out;
  psum_t     psum_in;
  logic      first_in;
  logic      last_in;
  acc_t      threshold_in;
  logic      flush_in;
  logic      act_valid_out;
  logic      act_ready_in;
  act_word_t activation_out;
`ifdef PSUM_BINARIZER_POLARITY_EN
  logic      polarity_in;

  modport master (
    output psum_valid_in, psum_in, first_in, last_in, threshold_in, flush_in,
           act_ready_in, polarity_in,
    input  psum_ready_out, act_valid_out, activation_out
  );
  modport slave (
    input  psum_valid_in, psum_in, first_in, last_in, threshold_in, flush_in,
           act_ready_in, polarity_in,
    output psum_ready_out, act_valid_out, activation_out
  );
`else
  modport master (
    output psum_valid_in, psum_in, first_in, last_in, threshold_in, flush_in,
           act_ready_in,
    input  psum_ready_out, act_valid_out, activation_out
  );
  modport slave (
    input  psum_valid_in, psum_in, first_in, last_in, threshold_in, flush_in,
           act_ready_in,
    output psum_ready_out, act_valid_out, activation_out
  );
`endif

endinterface

// File: rtl/psum_binarizer_sat_accumulator.sv
// -----------------------------------------------------------------------------
// sat_accumulator
// Saturating signed accumulator for one PE column's psum stream.
//   clk_in, rst_in : clock, asynchronous active-low reset
//   en             : beat accepted this cycle; load acc_next into acc
//   first          : beat starts a new sum (accumulate onto zero)
//   psum           : incoming signed psum
//   acc_next       : combinational sum for the current beat, already clamped
// -----------------------------------------------------------------------------
module sat_accumulator
  import bnn_pkg::*;
(
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  en,
  input  logic  first,
  input  psum_t psum,
  output acc_t  acc_next
);

  acc_t acc;
  acc_t acc_base;

  always_comb begin
    acc_base = first ? '0 : acc;
    acc_next = sat_add(acc_base, psum);
  end

  // NOTE: registers use <= so every flop samples the pre-edge values; a
  // blocking = here would let later statements see the updated value.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      acc <= '0;
    else if (en)
      acc <= acc_next;
  end

endmodule

// File: rtl/psum_binarizer.sv
// -----------------------------------------------------------------------------
// psum_binarizer
// Accumulates a PE column's psum stream across input-channel tiles, applies a
// folded batch-norm threshold, and packs the resulting sign bits into 3x3
// activation words (bit0 = first produced).
//   clk_in, rst_in : clock, asynchronous active-low reset
//   bus (slave)    : psum stream in, flush pulse, packed activation out
// Optional: PSUM_BINARIZER_POLARITY_EN adds bus.polarity_in, which flips the
// compare to <= for channels with negative batch-norm gamma.
// -----------------------------------------------------------------------------
module psum_binarizer
  import bnn_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  psum_binarizer_if.slave  bus
);

  logic      slot_free;
  logic      accept;
  logic      drain;
  logic      act_bit;
  logic      word_full;
  logic      flush_req;
  logic      flush_exec;
  logic      emit;
  acc_t      acc_next;
  act_word_t pack, pack_upd;
  bit_idx_t  bit_idx, idx_upd;
  logic      flush_pending;
  logic      act_valid_q;
  act_word_t act_word_q;

  // The output slot is free when empty or being drained this cycle; beats are
  // only taken then, so a completed word always has somewhere to go.
  assign slot_free          = !act_valid_q || bus.act_ready_in;
  assign bus.psum_ready_out = slot_free;
  assign bus.act_valid_out  = act_valid_q;
  assign bus.activation_out = act_word_q;

  assign accept = bus.psum_valid_in && slot_free;
  assign drain  = act_valid_q && bus.act_ready_in;

  sat_accumulator u_acc (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en       (accept),
    .first    (bus.first_in),
    .psum     (bus.psum_in),
    .acc_next (acc_next)
  );

`ifdef PSUM_BINARIZER_POLARITY_EN
  assign act_bit = bus.polarity_in ? (acc_next <= bus.threshold_in)
                                   : (acc_next >= bus.threshold_in);
`else
  assign act_bit = (acc_next >= bus.threshold_in);
`endif

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    pack_upd  = pack;
    idx_upd   = bit_idx;
    word_full = 1'b0;
    if (accept && bus.last_in) begin
      pack_upd[bit_idx] = act_bit;
      idx_upd           = bit_idx + 1'b1;
      word_full         = (bit_idx == bit_idx_t'(KBITS - 1));
    end
    // The pulse itself can execute in its own cycle; pending only covers the
    // case where the slot is occupied.
    flush_req  = bus.flush_in || flush_pending;
    flush_exec = flush_req && slot_free;
    // Flush sees the packer after this cycle's bit, so a bit that completes
    // the word yields a single emission, not a full word plus an empty one.
    emit       = word_full || (flush_exec && (idx_upd != '0));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pack          <= '0;
      bit_idx       <= '0;
      flush_pending <= 1'b0;
      act_valid_q   <= 1'b0;
      act_word_q    <= '0;
    end else begin
      flush_pending <= flush_req && !slot_free;
      if (emit) begin
        pack        <= '0;
        bit_idx     <= '0;
        act_valid_q <= 1'b1;
        act_word_q  <= pack_upd;
      end else begin
        pack    <= pack_upd;
        bit_idx <= idx_upd;
        if (drain)
          act_valid_q <= 1'b0;
      end
    end
  end

endmodule
